branch_pred_unit: RTL and testbench
===================================

Name: branch_pred_unit

Overview:
Parametrised dynamic branch predictor replacing the fixed predict-not-taken policy of the IF stage in the 5-stage RV32I pipeline. It has a direct-mapped BTB (tag, target, valid) and a table of saturating counters. Prediction is combinational from pc_i in IF. Training comes from the resolved branch in EX/MEM, the same point where miss_pred is raised.

Parameters:
XLEN, 32, address/data width
ENTRIES, 64, number of BTB/counter entries; power of 2, >= 4
TAG_W, 8, BTB tag width; IDX_W+TAG_W+2 <= XLEN
CNT_W, 2, saturating counter width, >= 1
GHR_W, 6, global history length (used only with GSHARE_EN); must be <= IDX_W

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
pc_i  input  XLEN  fetch PC (IF stage)
pred_taken_o  output  1  predicted taken
pred_target_o  output  XLEN  predicted target; 0 when pred_taken_o=0
pred_ghr_o  output  GHR_W  history snapshot used for this lookup; carried down the pipe
upd_valid_i  input  1  resolved control-flow instruction in EX/MEM this cycle
upd_cond_i  input  1  1 = conditional branch; 0 = JAL/JALR
upd_pc_i  input  XLEN  PC of the resolved instruction
upd_taken_i  input  1  actual outcome
upd_target_i  input  XLEN  actual target
upd_ghr_i  input  GHR_W  pred_ghr_o captured at its fetch
upd_mispred_i  input  1  pipeline detected a misprediction
flush_i  input  1  synchronous invalidate of all BTB entries (fence.i)
stat_lookups_o  output  32  number of pc_i lookups
stat_mispred_o  output  32  number of mispredictions

Behaviour:
- IDX_W = log2(ENTRIES). idx = pc[IDX_W+1:2]. tag = pc[IDX_W+TAG_W+1:IDX_W+2].
- Lookup (combinational, 0 latency):
  - hit = valid[idx] and tag match.
  - pred_taken_o = hit and (counter MSB = 1, or the entry is unconditional).
  - pred_target_o = target[idx] when taken, else 0.
- Update, on the clock edge with upd_valid_i=1:
  - hit, conditional: counter increments when taken and decrements when not taken, saturating at 0 and 2^CNT_W-1. Target is rewritten when taken.
  - miss and taken: allocate the entry, overwriting any previous occupant. Write tag, target and the uncond flag = !upd_cond_i. Counter is set to the weakly-taken value 2^(CNT_W-1).
  - miss and not taken: no change to the table.
  - hit, unconditional: target rewritten; counter is not modified.
- Same-cycle lookup and update to the same index: the lookup returns the pre-update contents (no bypass).
- flush_i clears all valid bits on the clock edge. Counters are kept. If flush_i and upd_valid_i occur in the same cycle, flush wins and no allocation happens.
- Statistics counters:
  - stat_lookups_o increments every cycle that reset=0.
  - stat_mispred_o increments when upd_valid_i and upd_mispred_i are both 1.
  - Both wrap modulo 2^32.
- Reset (async): all valid=0, counters=2^(CNT_W-1), targets/tags=0, stats=0, GHR=0. Outputs after reset: pred_taken_o=0, pred_target_o=0, pred_ghr_o=0.
- Reset asserted mid-update: the update is lost; the table is in its reset state.

Optional Feature:
GSHARE_EN.
- Defined:
  - Counter index = idx XOR zero-extended GHR. BTB stays indexed by idx.
  - On conditional updates, GHR <= {GHR[GHR_W-2:0], upd_taken_i}.
  - On an update with upd_mispred_i, GHR is instead repaired to {upd_ghr_i[GHR_W-2:0], upd_taken_i}.
  - Counter update uses upd_ghr_i for its index.
  - pred_ghr_o = GHR.
- Undefined: bimodal indexing only; no GHR register; pred_ghr_o tied to 0; upd_ghr_i ignored.

Decomposition:
- Shared package bp_pkg holds:
  - counter enum/constants: CNT_WEAK_T = 2^(CNT_W-1), CNT_MAX;
  - an index/tag extraction function;
  - the stats width constant.
- One sub-module: sat_counter_table (ENTRIES x CNT_W). It provides the read port, the write port with saturating inc/dec, and the reset/init value. The BTB arrays and GHR stay in the top module.

Test Plan:
- Reset, then pc_i=0x100 -> pred_taken_o=0, pred_target_o=0, stat_lookups_o counts from 0.
- Update: pc=0x100, cond, taken, target=0x80. Next cycle pc_i=0x100 -> pred_taken_o=1, pred_target_o=0x80 (counter=2).
- Two not-taken updates at 0x100 -> counter 2→1→0, prediction 0. A third not-taken update -> counter stays 0. Four taken updates -> counter saturates at 3.
- Aliasing: with ENTRIES=64, allocate 0x100, then update taken at 0x200 (same idx, different tag) -> lookup 0x100 misses (pred 0), lookup 0x200 hits.
- JAL at 0x40 → 0x400 -> predicted taken on the next lookup. flush_i pulse -> pred 0. flush_i + update in the same cycle -> no allocation.
- Same-cycle lookup/update at 0x100 -> the lookup shows old data. Three mispred updates -> stat_mispred_o=3. GSHARE_EN build: history 0b000001 steers the counter index to idx^1.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared definitions for branch_pred_unit: counter update ops and values,
// PC index/tag field extraction, statistics width.
package bp_pkg;

  localparam int STAT_W = 32;

  typedef enum logic [1:0] {
    CNT_HOLD,
    CNT_INC,
    CNT_DEC,
    CNT_INIT
  } cnt_op_e;

  // Weakly-taken value 2^(CNT_W-1): lowest value whose MSB predicts taken.
  function automatic int unsigned cnt_weak_t(input int unsigned cnt_w);
    return 32'd1 << (cnt_w - 32'd1);
  endfunction

  function automatic int unsigned cnt_max(input int unsigned cnt_w);
    return (32'd1 << cnt_w) - 32'd1;
  endfunction

  // Extracts pc[lsb +: width]; used for both the index and the tag.
  function automatic logic [63:0] pc_field(input logic [63:0] pc,
                                           input int unsigned lsb,
                                           input int unsigned width);
    return (pc >> lsb) & ((64'd1 << width) - 64'd1);
  endfunction

endpackage

// File: rtl/sat_counter_table.sv
// ENTRIES x CNT_W saturating direction counters: one combinational read port,
// one write port applying hold / saturating inc / saturating dec / init.
module sat_counter_table
  import bp_pkg::*;
#(
  parameter  int ENTRIES = 64,
  parameter  int CNT_W   = 2,
  localparam int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [CNT_W-1:0] rd_cnt,
  input  logic [IDX_W-1:0] wr_idx,
  input  cnt_op_e          wr_op
);

  localparam logic [CNT_W-1:0] CNT_WEAK_T = CNT_W'(cnt_weak_t(CNT_W));
  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(cnt_max(CNT_W));

  logic [CNT_W-1:0] cnt_q [ENTRIES];

  assign rd_cnt = cnt_q[rd_idx];

  // NOTE: the counters are flops, not a RAM, so every entry is reset explicitly
  // to weakly-taken; a RAM would power up with garbage predictions.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) cnt_q[i] <= CNT_WEAK_T;
    end else begin
      // NOTE: non-blocking assignment, so the compare above each update reads
      // the pre-edge value and ordering between statements cannot matter.
      unique case (wr_op)
        CNT_INC:  if (cnt_q[wr_idx] != CNT_MAX) cnt_q[wr_idx] <= cnt_q[wr_idx] + 1'b1;
        CNT_DEC:  if (cnt_q[wr_idx] != '0)      cnt_q[wr_idx] <= cnt_q[wr_idx] - 1'b1;
        CNT_INIT: cnt_q[wr_idx] <= CNT_WEAK_T;
        default:  ;
      endcase
    end
  end

endmodule

// File: rtl/branch_pred_unit.sv
// Dynamic branch predictor: direct-mapped BTB plus saturating-counter table.
// Define GSHARE_EN to index the counters with PC xor global history (gshare).
module branch_pred_unit
  import bp_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 64,
  parameter int TAG_W   = 8,
  parameter int CNT_W   = 2,
  parameter int GHR_W   = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [XLEN-1:0]   pc_i,
  output logic              pred_taken_o,
  output logic [XLEN-1:0]   pred_target_o,
  output logic [GHR_W-1:0]  pred_ghr_o,
  input  logic              upd_valid_i,
  input  logic              upd_cond_i,
  input  logic [XLEN-1:0]   upd_pc_i,
  input  logic              upd_taken_i,
  input  logic [XLEN-1:0]   upd_target_i,
  input  logic [GHR_W-1:0]  upd_ghr_i,
  input  logic              upd_mispred_i,
  input  logic              flush_i,
  output logic [STAT_W-1:0] stat_lookups_o,
  output logic [STAT_W-1:0] stat_mispred_o
);

  localparam int IDX_W = $clog2(ENTRIES);

  logic              valid_q  [ENTRIES];
  logic              uncond_q [ENTRIES];
  logic [TAG_W-1:0]  tag_q    [ENTRIES];
  logic [XLEN-1:0]   target_q [ENTRIES];
  logic [STAT_W-1:0] lookups_q, mispred_q;

  logic [IDX_W-1:0] lk_idx, up_idx, lk_cidx, up_cidx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic [CNT_W-1:0] lk_cnt;
  logic             lk_hit, up_hit, btb_we, alloc;
  cnt_op_e          cnt_op;

  assign lk_idx = IDX_W'(pc_field(64'(pc_i), 2, IDX_W));
  assign lk_tag = TAG_W'(pc_field(64'(pc_i), IDX_W + 2, TAG_W));
  assign up_idx = IDX_W'(pc_field(64'(upd_pc_i), 2, IDX_W));
  assign up_tag = TAG_W'(pc_field(64'(upd_pc_i), IDX_W + 2, TAG_W));

`ifdef GSHARE_EN
  logic [GHR_W-1:0] ghr_q;

  // Training uses the history captured at fetch, not the current one.
  assign lk_cidx    = lk_idx ^ IDX_W'(ghr_q);
  assign up_cidx    = up_idx ^ IDX_W'(upd_ghr_i);
  assign pred_ghr_o = ghr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ghr_q <= '0;
    end else if (upd_valid_i) begin
      if (upd_mispred_i)   ghr_q <= {upd_ghr_i[GHR_W-2:0], upd_taken_i};
      else if (upd_cond_i) ghr_q <= {ghr_q[GHR_W-2:0], upd_taken_i};
    end
  end
`else
  logic unused_ghr;

  assign unused_ghr = ^upd_ghr_i;
  assign lk_cidx    = lk_idx;
  assign up_cidx    = up_idx;
  assign pred_ghr_o = '0;
`endif

  sat_counter_table #(
    .ENTRIES (ENTRIES),
    .CNT_W   (CNT_W)
  ) u_cnt (
    .clk    (clk),
    .reset  (reset),
    .rd_idx (lk_cidx),
    .rd_cnt (lk_cnt),
    .wr_idx (up_cidx),
    .wr_op  (cnt_op)
  );

  // Lookup reads registered state only, so a same-cycle update is not visible.
  assign lk_hit        = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign pred_taken_o  = lk_hit && (lk_cnt[CNT_W-1] || uncond_q[lk_idx]);
  assign pred_target_o = pred_taken_o ? target_q[lk_idx] : '0;

  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    cnt_op = CNT_HOLD;
    btb_we = 1'b0;
    alloc  = 1'b0;
    if (upd_valid_i && !flush_i) begin
      if (up_hit) begin
        if (upd_cond_i) cnt_op = upd_taken_i ? CNT_INC : CNT_DEC;
        btb_we = upd_taken_i || !upd_cond_i;
      end else if (upd_taken_i) begin
        cnt_op = CNT_INIT;
        btb_we = 1'b1;
        alloc  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        uncond_q[i] <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
      end
    end else if (flush_i) begin
      for (int i = 0; i < ENTRIES; i++) valid_q[i] <= 1'b0;
    end else if (btb_we) begin
      target_q[up_idx] <= upd_target_i;
      if (alloc) begin
        valid_q[up_idx]  <= 1'b1;
        tag_q[up_idx]    <= up_tag;
        uncond_q[up_idx] <= !upd_cond_i;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lookups_q <= '0;
      mispred_q <= '0;
    end else begin
      lookups_q <= lookups_q + 1'b1;
      if (upd_valid_i && upd_mispred_i) mispred_q <= mispred_q + 1'b1;
    end
  end

  assign stat_lookups_o = lookups_q;
  assign stat_mispred_o = mispred_q;

endmodule

// File: tb/tb_branch_pred_unit.sv
// Self-checking bench for branch_pred_unit: directed vector table, a mid-update
// reset sequence, and randomized traffic against a behavioural model.
module tb_branch_pred_unit;

  localparam int XLEN    = 32;
  localparam int ENTRIES = 64;
  localparam int TAG_W   = 8;
  localparam int CNT_W   = 2;
  localparam int GHR_W   = 6;
  localparam int CMAX    = (1 << CNT_W) - 1;
  localparam int CWEAK   = 1 << (CNT_W - 1);

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [XLEN-1:0]  pc_i = '0;
  logic             pred_taken_o;
  logic [XLEN-1:0]  pred_target_o;
  logic [GHR_W-1:0] pred_ghr_o;
  logic             upd_valid_i = 1'b0;
  logic             upd_cond_i = 1'b0;
  logic [XLEN-1:0]  upd_pc_i = '0;
  logic             upd_taken_i = 1'b0;
  logic [XLEN-1:0]  upd_target_i = '0;
  logic [GHR_W-1:0] upd_ghr_i = '0;
  logic             upd_mispred_i = 1'b0;
  logic             flush_i = 1'b0;
  logic [31:0]      stat_lookups_o, stat_mispred_o;

  branch_pred_unit #(
    .XLEN(XLEN), .ENTRIES(ENTRIES), .TAG_W(TAG_W), .CNT_W(CNT_W), .GHR_W(GHR_W)
  ) dut (
    .clk(clk), .reset(reset), .pc_i(pc_i),
    .pred_taken_o(pred_taken_o), .pred_target_o(pred_target_o), .pred_ghr_o(pred_ghr_o),
    .upd_valid_i(upd_valid_i), .upd_cond_i(upd_cond_i), .upd_pc_i(upd_pc_i),
    .upd_taken_i(upd_taken_i), .upd_target_i(upd_target_i), .upd_ghr_i(upd_ghr_i),
    .upd_mispred_i(upd_mispred_i), .flush_i(flush_i),
    .stat_lookups_o(stat_lookups_o), .stat_mispred_o(stat_mispred_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---- behavioural model: one record per BTB slot, counters as plain ints ----
  typedef struct {
    bit          valid;
    int unsigned tag;
    logic [31:0] target;
    bit          uncond;
  } m_ent_t;

  m_ent_t      m_btb [ENTRIES];
  int          m_cnt [ENTRIES];
  int unsigned m_ghr, m_lookups, m_mis;

  function automatic int unsigned idx_of(input logic [31:0] pc);
    return (pc / 4) % ENTRIES;
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] pc);
    return (pc / (4 * ENTRIES)) % (1 << TAG_W);
  endfunction

  function automatic int unsigned cidx_of(input int unsigned i, input int unsigned g);
`ifdef GSHARE_EN
    return i ^ g;
`else
    return i + 0 * g;
`endif
  endfunction

  task automatic m_reset();
    for (int k = 0; k < ENTRIES; k++) begin
      m_btb[k] = '{valid: 1'b0, tag: 0, target: '0, uncond: 1'b0};
      m_cnt[k] = CWEAK;
    end
    m_ghr = 0; m_lookups = 0; m_mis = 0;
  endtask

  task automatic m_predict(input logic [31:0] pc, output bit t, output logic [31:0] tg);
    int unsigned i, ci;
    bit hit;
    i   = idx_of(pc);
    ci  = cidx_of(i, m_ghr);
    hit = m_btb[i].valid && (m_btb[i].tag == tag_of(pc));
    t   = hit && (m_cnt[ci] >= CWEAK || m_btb[i].uncond);
    tg  = t ? m_btb[i].target : 32'h0;
  endtask

  // Applies the rules of one clock edge using the bench's own driven inputs.
  task automatic m_update();
    int unsigned i, ci, tg;
    bit hit;
    i  = idx_of(upd_pc_i);
    tg = tag_of(upd_pc_i);
    ci = cidx_of(i, upd_ghr_i);
    if (flush_i) begin
      for (int k = 0; k < ENTRIES; k++) m_btb[k].valid = 1'b0;
    end else if (upd_valid_i) begin
      hit = m_btb[i].valid && (m_btb[i].tag == tg);
      if (hit) begin
        if (upd_cond_i)
          m_cnt[ci] = upd_taken_i ? ((m_cnt[ci] < CMAX) ? m_cnt[ci] + 1 : CMAX)
                                  : ((m_cnt[ci] > 0) ? m_cnt[ci] - 1 : 0);
        if (upd_taken_i || !upd_cond_i) m_btb[i].target = upd_target_i;
      end else if (upd_taken_i) begin
        m_btb[i]  = '{valid: 1'b1, tag: tg, target: upd_target_i, uncond: !upd_cond_i};
        m_cnt[ci] = CWEAK;
      end
    end
    if (upd_valid_i) begin
      if (upd_mispred_i) begin
        m_mis++;
        m_ghr = (int'(upd_ghr_i) * 2 + int'(upd_taken_i)) % (1 << GHR_W);
      end else if (upd_cond_i) begin
        m_ghr = (m_ghr * 2 + int'(upd_taken_i)) % (1 << GHR_W);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset) begin
      m_update();
      m_lookups++;
    end
    #1;
  endtask

  task automatic set_upd(input bit v, input bit c, input logic [31:0] pc, input bit t,
                         input logic [31:0] tg, input bit mp, input bit fl);
    upd_valid_i = v; upd_cond_i = c; upd_pc_i = pc; upd_taken_i = t;
    upd_target_i = tg; upd_mispred_i = mp; flush_i = fl;
  endtask

  function automatic logic [31:0] rand_pc();
    return ((32'($urandom_range(0, 2)) * ENTRIES) + 32'($urandom_range(0, 7))) * 4;
  endfunction

  // ---- directed vectors: lookup checked first (pre-update), then the edge ----
  typedef struct {
    logic [31:0] lp;
    bit          uv, uc;
    logic [31:0] upc;
    bit          ut;
    logic [31:0] utg;
    bit          mp, fl;
    bit          et;
    logic [31:0] etg;
  } vec_t;

  function automatic vec_t mk(logic [31:0] lp, bit uv, bit uc, logic [31:0] upc, bit ut,
                              logic [31:0] utg, bit mp, bit fl, bit et, logic [31:0] etg);
    vec_t v;
    v = '{lp: lp, uv: uv, uc: uc, upc: upc, ut: ut, utg: utg, mp: mp, fl: fl, et: et, etg: etg};
    return v;
  endfunction

  initial begin
    vec_t vecs[$];
    bit          et;
    logic [31:0] etg;
    bit          fl, cnd;

    m_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    pc_i = 32'h100;
    #1;
    check("rst_taken",   32'(pred_taken_o), 0);
    check("rst_target",  pred_target_o, 0);
    check("rst_ghr",     32'(pred_ghr_o), 0);
    check("rst_lookups", stat_lookups_o, 0);
    check("rst_mispred", stat_mispred_o, 0);

`ifndef GSHARE_EN
    //           look     uv uc upc      ut  utg      mp fl  exp_t exp_tgt
    vecs.push_back(mk(32'h100, 0, 0, 32'h0,   0, 32'h0,   0, 0, 0, 32'h0));
    vecs.push_back(mk(32'h100, 1, 1, 32'h100, 1, 32'h80,  0, 0, 0, 32'h0));   // same-cycle: old data
    vecs.push_back(mk(32'h100, 1, 1, 32'h100, 0, 32'h0,   0, 0, 1, 32'h80));  // cnt 2
    vecs.push_back(mk(32'h100, 1, 1, 32'h100, 0, 32'h0,   0, 0, 0, 32'h0));   // cnt 1
    vecs.push_back(mk(32'h100, 1, 1, 32'h100, 0, 32'h0,   0, 0, 0, 32'h0));   // cnt 0
    vecs.push_back(mk(32'h100, 1, 1, 32'h100, 1, 32'h80,  0, 0, 0, 32'h0));   // still 0 (floor)
    vecs.push_back(mk(32'h100, 1, 1, 32'h100, 1, 32'h80,  0, 0, 0, 32'h0));   // cnt 1
    vecs.push_back(mk(32'h100, 1, 1, 32'h100, 1, 32'h80,  0, 0, 1, 32'h80));  // cnt 2
    vecs.push_back(mk(32'h100, 1, 1, 32'h100, 1, 32'h80,  0, 0, 1, 32'h80));  // cnt 3
    vecs.push_back(mk(32'h100, 1, 1, 32'h100, 0, 32'h0,   0, 0, 1, 32'h80));  // 3 held, no wrap
    vecs.push_back(mk(32'h100, 0, 0, 32'h0,   0, 32'h0,   0, 0, 1, 32'h80));  // cnt 2
    vecs.push_back(mk(32'h100, 1, 1, 32'h200, 1, 32'h300, 0, 0, 1, 32'h80));  // alias evicts
    vecs.push_back(mk(32'h100, 0, 0, 32'h0,   0, 32'h0,   0, 0, 0, 32'h0));
    vecs.push_back(mk(32'h200, 0, 0, 32'h0,   0, 32'h0,   0, 0, 1, 32'h300));
    vecs.push_back(mk(32'h40,  1, 0, 32'h40,  1, 32'h400, 0, 0, 0, 32'h0));   // JAL alloc
    vecs.push_back(mk(32'h40,  0, 0, 32'h0,   0, 32'h0,   0, 0, 1, 32'h400));
    vecs.push_back(mk(32'h40,  0, 0, 32'h0,   0, 32'h0,   0, 1, 1, 32'h400)); // flush
    vecs.push_back(mk(32'h40,  0, 0, 32'h0,   0, 32'h0,   0, 0, 0, 32'h0));
    vecs.push_back(mk(32'h200, 0, 0, 32'h0,   0, 32'h0,   0, 0, 0, 32'h0));
    vecs.push_back(mk(32'h40,  1, 0, 32'h40,  1, 32'h400, 0, 1, 0, 32'h0));   // flush beats alloc
    vecs.push_back(mk(32'h40,  1, 1, 32'h500, 0, 32'h0,   1, 0, 0, 32'h0));
    vecs.push_back(mk(32'h40,  1, 1, 32'h500, 0, 32'h0,   1, 0, 0, 32'h0));
    vecs.push_back(mk(32'h40,  1, 1, 32'h500, 0, 32'h0,   1, 0, 0, 32'h0));
    vecs.push_back(mk(32'h40,  1, 0, 32'h40,  1, 32'h400, 0, 0, 0, 32'h0));
    vecs.push_back(mk(32'h40,  1, 0, 32'h40,  1, 32'h480, 0, 0, 1, 32'h400)); // JAL retarget
    vecs.push_back(mk(32'h40,  0, 0, 32'h0,   0, 32'h0,   0, 0, 1, 32'h480));

    foreach (vecs[k]) begin
      pc_i = vecs[k].lp;
      set_upd(vecs[k].uv, vecs[k].uc, vecs[k].upc, vecs[k].ut, vecs[k].utg, vecs[k].mp, vecs[k].fl);
      #1;
      check($sformatf("dir%0d_taken", k),  32'(pred_taken_o), 32'(vecs[k].et));
      check($sformatf("dir%0d_target", k), pred_target_o, vecs[k].etg);
      tick();
    end
    set_upd(0, 0, 0, 0, 0, 0, 0);
    #1;
    check("dir_mispred_cnt", stat_mispred_o, 3);
    check("dir_lookup_cnt",  stat_lookups_o, m_lookups);
`endif

    // Reset asserted between edges while an allocating update is presented.
    pc_i = 32'h600;
    set_upd(1, 1, 32'h600, 1, 32'h700, 1, 0);
    #3 reset = 1'b1;
    @(posedge clk);
    #1 set_upd(0, 0, 0, 0, 0, 0, 0);
    #2 reset = 1'b0;
    m_reset();
    #1;
    check("rstmid_taken_600", 32'(pred_taken_o), 0);
    pc_i = 32'h40;
    #1;
    check("rstmid_taken_40", 32'(pred_taken_o), 0);
    check("rstmid_lookups",  stat_lookups_o, 0);
    check("rstmid_mispred",  stat_mispred_o, 0);

    for (int n = 0; n < 2000; n++) begin
      pc_i = rand_pc();
      fl   = ($urandom_range(0, 31) == 0);
      cnd  = ($urandom_range(0, 9) < 7);
      set_upd(!fl && ($urandom_range(0, 1) == 1), cnd, rand_pc(),
              cnd ? ($urandom_range(0, 1) == 1) : 1'b1,
              $urandom & 32'hffff_fffc, ($urandom_range(0, 4) == 0), fl);
      upd_ghr_i = GHR_W'($urandom);
      #1;
      m_predict(pc_i, et, etg);
      check("rnd_taken",  32'(pred_taken_o), 32'(et));
      check("rnd_target", pred_target_o, etg);
`ifdef GSHARE_EN
      check("rnd_ghr", 32'(pred_ghr_o), m_ghr);
`else
      check("rnd_ghr", 32'(pred_ghr_o), 0);
`endif
      tick();
    end
    set_upd(0, 0, 0, 0, 0, 0, 0);
    #1;
    check("rnd_lookup_cnt",  stat_lookups_o, m_lookups);
    check("rnd_mispred_cnt", stat_mispred_o, m_mis);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
